scramble_seq_ctrl: RTL and testbench
====================================

SCRAMBLE_SEQ_CTRL -- requirements
Module: scramble_seq_ctrl

Interface
REQ-001 SHALL have parameter LFSR_WIDTH, default 4: LFSR state width.
REQ-002 SHALL have parameter LFSR_POLY, default 5'b10011: feedback polynomial (x^4+x+1), bit LFSR_WIDTH is the MSB term.
REQ-003 SHALL have parameter LFSR_SEED, default 1: nonzero reset value of the LFSR.
REQ-004 SHALL have parameter OUT_NO, default 2**LFSR_WIDTH-1: number of enable outputs.
REQ-005 SHALL have parameter KEY_W, default 8, and parameter KEY, default 8'hA5: unlock key width and value.
REQ-006 SHALL have parameter MAX_FAIL, default 3: wrong-key attempts before lockout.
REQ-007 SHALL have port clk  input  1  sole clock, rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port start  input  1  unlock request, sampled each cycle.
REQ-010 SHALL have port key  input  KEY_W  key presented with start.
REQ-011 SHALL have port steps  input  8  LFSR advance count, sampled with accepted start.
REQ-012 SHALL have port relock  input  1  return to locked idle.
REQ-013 SHALL have port enables  output  OUT_NO  one-hot segment enables.
REQ-014 SHALL have port lfsr_state  output  LFSR_WIDTH  current LFSR value.
REQ-015 SHALL have ports busy, done, lockout  output  1 each  status flags.

Function
REQ-016 SHALL implement states IDLE, RUN, HOLD, LOCKOUT; all outputs registered.
REQ-017 SHALL advance the LFSR as next = {s[W-2:0], fb}, fb = XOR of (s & LFSR_POLY[W:1]); defaults give 1,3,7,15,14,13,10,5,11,6,12,9,2,4,8,1.
REQ-018 SHALL advance the LFSR only in RUN, exactly one step per cycle; held otherwise.
REQ-019 IDLE: start=1 with key==KEY SHALL clear fail count, load counter=steps, go to RUN (steps!=0) or HOLD (steps==0) next cycle.
REQ-020 IDLE: start=1 with key!=KEY SHALL increment fail count; on reaching MAX_FAIL go to LOCKOUT, else stay IDLE.
REQ-021 RUN: busy=1; each cycle LFSR advances and counter decrements; the step that brings counter to 0 transitions to HOLD; busy high exactly steps cycles.
REQ-022 HOLD: done=1; enables[lfsr_state-1]=1, all other enables 0.
REQ-023 enables SHALL be all-zero in IDLE, RUN and LOCKOUT (no intermediate decodes exposed).
REQ-024 HOLD: relock=1 SHALL return to IDLE next cycle, clear enables/done, retain lfsr_state (sequence continues on next unlock).
REQ-025 relock SHALL be ignored in IDLE, RUN, LOCKOUT; start SHALL be ignored in RUN, HOLD, LOCKOUT.
REQ-026 HOLD with start and relock both high: relock wins, start not evaluated.
REQ-027 LOCKOUT: lockout=1, enables=0, busy=0, done=0; exited only by reset.
REQ-028 steps wrap: steps=15 (period) SHALL return LFSR to its pre-run value.
REQ-029 lfsr_state SHALL never become 0.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, lfsr_state=LFSR_SEED, counter=0, fail count=0, enables=0, busy=0, done=0, lockout=0, from any state including mid-RUN and LOCKOUT.
REQ-031 reset SHALL take priority over start and relock in the same cycle.

Verification
REQ-032 Reset; start, key=8'hA5, steps=3 -> busy 3 cycles, lfsr 1->3->7->15, then HOLD, done=1, enables=1<<14.
REQ-033 From REQ-032 HOLD: relock, then start key=8'hA5 steps=2 -> lfsr 15->14->13, enables=1<<12.
REQ-034 Reset; start key=8'hA5 steps=0 -> next cycle HOLD, busy never high, lfsr=1, enables=1<<0.
REQ-035 Reset; three starts key=8'h00 -> lockout=1 after third; later start key=8'hA5 -> no change; reset -> lockout=0.
REQ-036 Reset; two wrong keys, one correct (steps=1), relock, two wrong keys -> no lockout (count cleared).
REQ-037 Start steps=10, reset=0 on fourth RUN cycle -> next cycle IDLE, lfsr=1, busy=0, enables=0.

Source files
------------

// File: rtl/scramble_seq_ctrl.sv
// scramble_seq_ctrl: key-gated LFSR sequencer.
// A correct key advances a Galois-free (Fibonacci shift) LFSR a requested
// number of steps, then exposes a one-hot segment enable selected by the
// resulting LFSR value until relocked. Repeated wrong keys lock the block
// until reset. Every output is driven directly from a register.
module scramble_seq_ctrl #(
  parameter int                    LFSR_WIDTH = 4,
  parameter logic [LFSR_WIDTH:0]   LFSR_POLY  = 5'b10011,
  parameter logic [LFSR_WIDTH-1:0] LFSR_SEED  = 4'd1,
  parameter int                    OUT_NO     = 2**LFSR_WIDTH - 1,
  parameter int                    KEY_W      = 8,
  parameter logic [KEY_W-1:0]      KEY        = 8'hA5,
  parameter int                    MAX_FAIL   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [KEY_W-1:0]      key,
  input  logic [7:0]            steps,
  input  logic                  relock,
  output logic [OUT_NO-1:0]     enables,
  output logic [LFSR_WIDTH-1:0] lfsr_state,
  output logic                  busy,
  output logic                  done,
  output logic                  lockout
);

  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    HOLD    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic [LFSR_WIDTH-1:0]   lfsr_r;
  logic [LFSR_WIDTH-1:0]   lfsr_nxt_s;
  logic [7:0]              cnt_r;
  logic [7:0]              cnt_nxt_s;
  logic [FAIL_W-1:0]       fail_r;
  logic [FAIL_W-1:0]       fail_nxt_s;
  logic [FAIL_W-1:0]       fail_inc_s;
  logic [OUT_NO-1:0]       enables_r;
  logic [OUT_NO-1:0]       enables_nxt_s;
  logic                    busy_r;
  logic                    done_r;
  logic                    lockout_r;

  // One LFSR step: shift left, feed back the parity of the tapped bits.
  // An all-zero result can only arise from a corrupted state; it is
  // steered back to the seed so the register can never stick at zero.
  function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] s);
    logic                  fb;
    logic [LFSR_WIDTH-1:0] n;
    fb = ^(s & LFSR_POLY[LFSR_WIDTH:1]);
    n  = {s[LFSR_WIDTH-2:0], fb};
    if (n == '0) begin
      return LFSR_SEED;
    end else begin
      return n;
    end
  endfunction

  assign fail_inc_s = fail_r + FAIL_W'(1);

  // Next-state logic for the FSM, LFSR, step counter and fail counter.
  always_comb begin
    state_nxt_s = state_r;
    lfsr_nxt_s  = lfsr_r;
    cnt_nxt_s   = cnt_r;
    fail_nxt_s  = fail_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (key == KEY) begin
            fail_nxt_s = '0;
            cnt_nxt_s  = steps;
            if (steps != 8'd0) begin
              state_nxt_s = RUN;
            end else begin
              state_nxt_s = HOLD;
            end
          end else begin
            fail_nxt_s = fail_inc_s;
            if (fail_inc_s >= FAIL_W'(MAX_FAIL)) begin
              state_nxt_s = LOCKOUT;
            end else begin
              state_nxt_s = IDLE;
            end
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        lfsr_nxt_s = lfsr_step(lfsr_r);
        cnt_nxt_s  = cnt_r - 8'd1;
        if (cnt_r == 8'd1) begin
          state_nxt_s = HOLD;
        end else begin
          state_nxt_s = RUN;
        end
      end
      HOLD: begin
        // relock has priority; start is not looked at while holding.
        if (relock) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      LOCKOUT: begin
        state_nxt_s = LOCKOUT;
      end
      default: begin
        state_nxt_s = IDLE;
        lfsr_nxt_s  = LFSR_SEED;
        cnt_nxt_s   = 8'd0;
      end
    endcase
  end

  // Decode the segment enable from the LFSR value that HOLD will show.
  always_comb begin
    enables_nxt_s = '0;
    if (state_nxt_s == HOLD) begin
      for (int i = 0; i < OUT_NO; i++) begin
        if (lfsr_nxt_s == LFSR_WIDTH'(i + 1)) begin
          enables_nxt_s[i] = 1'b1;
        end else begin
          enables_nxt_s[i] = 1'b0;
        end
      end
    end else begin
      enables_nxt_s = '0;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r   <= IDLE;
      lfsr_r    <= LFSR_SEED;
      cnt_r     <= 8'd0;
      fail_r    <= '0;
      enables_r <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      lockout_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      lfsr_r    <= lfsr_nxt_s;
      cnt_r     <= cnt_nxt_s;
      fail_r    <= fail_nxt_s;
      enables_r <= enables_nxt_s;
      busy_r    <= (state_nxt_s == RUN);
      done_r    <= (state_nxt_s == HOLD);
      lockout_r <= (state_nxt_s == LOCKOUT);
    end
  end

  assign enables    = enables_r;
  assign lfsr_state = lfsr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign lockout    = lockout_r;

endmodule

// File: tb/tb_scramble_seq_ctrl.sv
// Scoreboard bench for scramble_seq_ctrl: the driver applies one input
// vector per cycle and queues the hand-computed post-edge outputs; an
// independent monitor pops and compares after each rising edge.
module tb_scramble_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  key = 8'h00;
  logic [7:0]  steps = 8'h00;
  logic        relock = 1'b0;
  logic [14:0] enables;
  logic [3:0]  lfsr_state;
  logic        busy;
  logic        done;
  logic        lockout;

  typedef struct {
    logic        busy;
    logic        done;
    logic        lockout;
    logic [3:0]  lfsr;
    logic [14:0] en;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // Hand-written LFSR order for the default polynomial and seed.
  logic [3:0] seq [0:15] = '{4'd1, 4'd3, 4'd7, 4'd15, 4'd14, 4'd13, 4'd10, 4'd5,
                             4'd11, 4'd6, 4'd12, 4'd9, 4'd2, 4'd4, 4'd8, 4'd1};

  scramble_seq_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .steps      (steps),
    .relock     (relock),
    .enables    (enables),
    .lfsr_state (lfsr_state),
    .busy       (busy),
    .done       (done),
    .lockout    (lockout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge and queue the outputs
  // expected after the following rising edge.
  task automatic step(input logic rst_n, input logic st, input logic [7:0] k,
                      input logic [7:0] stp, input logic rl,
                      input logic eb, input logic ed, input logic el,
                      input logic [3:0] elfsr, input logic [14:0] een,
                      input string nm);
    exp_t e;
    @(negedge clk);
    reset  = rst_n;
    start  = st;
    key    = k;
    steps  = stp;
    relock = rl;
    e.busy = eb; e.done = ed; e.lockout = el; e.lfsr = elfsr; e.en = een; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (busy === e.busy && done === e.done && lockout === e.lockout &&
            lfsr_state === e.lfsr && enables === e.en) begin
          passed++;
        end else begin
          $display("FAIL %s: got busy=%b done=%b lockout=%b lfsr=%0d en=%h, want busy=%b done=%b lockout=%b lfsr=%0d en=%h",
                   e.name, busy, done, lockout, lfsr_state, enables,
                   e.busy, e.done, e.lockout, e.lfsr, e.en);
        end
      end
    end
  end

  initial begin
    int wait_cnt;
    // Basic unlock, 3 steps, then relock and a 2-step continuation.
    step(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "reset_state");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "idle_relock_ignored");
    step(1'b1, 1'b1, 8'hA5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 15'h0, "run1_lfsr1");
    step(1'b1, 1'b1, 8'h00, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 15'h0, "run2_start_ignored");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 15'h0, "run3_relock_ignored");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 15'h4000, "hold_lfsr15");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd15, 15'h4000, "hold_stays");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 15'h0, "relock_to_idle");
    step(1'b1, 1'b1, 8'hA5, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 15'h0, "run_b1");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd14, 15'h0, "run_b2");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 15'h1000, "hold_lfsr13");
    step(1'b1, 1'b1, 8'hA5, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 15'h1000, "hold_start_ignored");
    step(1'b1, 1'b1, 8'hA5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd13, 15'h0, "relock_beats_start");

    // Zero steps: straight to HOLD with the seed value.
    step(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "reset_b");
    step(1'b1, 1'b1, 8'hA5, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 15'h0001, "steps0_hold");

    // Lockout after three wrong keys; only reset (which beats start) clears it.
    step(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "reset_c");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "wrong1");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "wrong2");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 15'h0, "wrong3_lockout");
    step(1'b1, 1'b1, 8'hA5, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 15'h0, "lockout_start_ignored");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 15'h0, "lockout_relock_ignored");
    step(1'b0, 1'b1, 8'hA5, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "reset_beats_start");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "idle_after_lockout");

    // A correct key clears the fail count.
    step(1'b1, 1'b1, 8'h3C, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "d_wrong1");
    step(1'b1, 1'b1, 8'hA4, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "d_wrong2");
    step(1'b1, 1'b1, 8'hA5, 8'd1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 15'h0, "d_correct_run");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 15'h0004, "d_hold_lfsr3");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 15'h0, "d_relock");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 15'h0, "d_wrong_a");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 15'h0, "d_wrong_b_no_lock");
    step(1'b1, 1'b1, 8'h00, 8'd1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 15'h0, "d_wrong_c_lock");

    // Reset in the middle of a 10-step run.
    step(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "reset_e");
    step(1'b1, 1'b1, 8'hA5, 8'd10, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 15'h0, "e_run1");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 15'h0, "e_run2");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 15'h0, "e_run3");
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 15'h0, "e_run4");
    step(1'b0, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 15'h0, "e_reset_midrun");

    // Full period: 15 steps return to the starting value.
    step(1'b1, 1'b1, 8'hA5, 8'd15, 1'b0, 1'b1, 1'b0, 1'b0, seq[0], 15'h0, "f_run_start");
    for (int i = 1; i < 15; i++) begin
      step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, seq[i], 15'h0, "f_run_seq");
    end
    step(1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, seq[15], 15'h0001, "f_period_hold");

    // Drain the scoreboard within a bounded number of cycles.
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 10) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
